// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: NOP encoding, FSM state codes, default reset PC.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] IF_BOOT = 2'd0;
    localparam logic [1:0] IF_RUN  = 2'd1;
    localparam logic [1:0] IF_HOLD = 2'd2;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Fetch/bubble event counters for the fetch stage; 32-bit, wrapping, cleared on reset.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
);

    logic [31:0] fetch_q;
    logic [31:0] bubble_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_q  <= 32'h0;
            bubble_q <= 32'h0;
        end else if (flush) begin
            bubble_q <= bubble_q + 32'd1;
        end else begin
            fetch_q <= fetch_q + 32'd1;
        end
    end

    assign fetch_cnt  = fetch_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32IM instruction-fetch stage: PC ownership, boot, stall hold and zero-bubble redirects.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc1,
    output logic        flush,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
);

    logic [31:0] pc_q;
    logic [31:0] pc1_q;
    logic [1:0]  state;
    logic [31:0] br_aligned;
    logic        booting;
    logic        unused_tgt_bits;

    assign br_aligned      = {br_target[31:2], 2'b00};
    assign unused_tgt_bits = ^br_target[1:0];
    assign booting         = (state == IF_BOOT);

    // Redirect target goes straight to memory so the target word lands on ir next cycle.
    always_comb begin
        imem_addr = pc_q;
        if (br_taken) begin
            imem_addr = br_aligned;
        end else if (!booting && stall) begin
            imem_addr = pc1_q;
        end
    end

    assign ir    = booting ? NOP_INSN : imem_rdata;
    assign pc1   = pc1_q;
    assign flush = booting | stall | br_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            pc1_q <= RESET_PC;
            state <= IF_BOOT;
        end else if (br_taken) begin
            pc1_q <= br_aligned;
            pc_q  <= pc_plus4(br_aligned);
            state <= IF_RUN;
        end else if (stall && !booting) begin
            state <= IF_HOLD;
        end else begin
            pc1_q <= pc_q;
            pc_q  <= pc_plus4(pc_q);
            state <= IF_RUN;
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_counter u_perf (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fetch_cnt  (perf_fetch_cnt),
        .bubble_cnt (perf_bubble_cnt)
    );
`else
    assign perf_fetch_cnt  = 32'h0;
    assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a synchronous instruction-memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NV = 15;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] pc1;
    logic        flush;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .ir              (ir),
        .pc1             (pc1),
        .flush           (flush),
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        flush;
        logic [31:0] addr;
        logic [31:0] pc1;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[NV];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_bub;
        int exp_fet;

        // stall br  target        flush addr           pc1            ir
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h0,         NOP};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h4,         32'h0,         32'h0050_0093};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h8,         32'h4,         32'h0010_0113};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h8,         mem_word(32'h8)};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h8,         mem_word(32'h8)};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'hC,         32'h8,         mem_word(32'h8)};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h10,        32'hC,         mem_word(32'hC)};
        vecs[7]  = '{1'b0, 1'b1, 32'h102,       1'b1, 32'h100,       32'h10,        mem_word(32'h10)};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h104,       32'h100,       mem_word(32'h100)};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h108,       32'h104,       mem_word(32'h104)};
        vecs[10] = '{1'b1, 1'b1, 32'h40,        1'b1, 32'h40,        32'h108,       mem_word(32'h108)};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h44,        32'h40,        mem_word(32'h40)};
        vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h44,        mem_word(32'h44)};
        vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)};
        vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h4,         32'h0,         32'h0050_0093};

        rst = 1'b1;
        stall = 1'b0;
        br_taken = 1'b0;
        br_target = 32'h0;
        #1;
        chk("reset_flush", {31'h0, flush}, 32'h1);
        chk("reset_ir", ir, NOP);
        chk("reset_pc1", pc1, 32'h0);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_perf_fetch", perf_fetch_cnt, 32'h0);
        chk("reset_perf_bubble", perf_bubble_cnt, 32'h0);
        repeat (2) next_cycle();
        rst = 1'b0;

        exp_bub = 0;
        exp_fet = 0;
        for (int i = 0; i < NV; i++) begin
            stall = vecs[i].stall;
            br_taken = vecs[i].br;
            br_target = vecs[i].tgt;
            @(negedge clk);
            chk($sformatf("v%0d_flush", i), {31'h0, flush}, {31'h0, vecs[i].flush});
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_pc1", i), pc1, vecs[i].pc1);
            chk($sformatf("v%0d_ir", i), ir, vecs[i].ir);
            if (vecs[i].flush) exp_bub++;
            else exp_fet++;
            next_cycle();
        end
        stall = 1'b0;
        br_taken = 1'b0;
        br_target = 32'h0;

`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 32'(exp_fet));
        chk("perf_bubble", perf_bubble_cnt, 32'(exp_bub));
`else
        chk("perf_fetch_tied", perf_fetch_cnt, 32'h0);
        chk("perf_bubble_tied", perf_bubble_cnt, 32'h0);
`endif

        // Async reset pulse in the middle of a stalled cycle.
        stall = 1'b1;
        #2;
        chk("stall_before_rst_flush", {31'h0, flush}, 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_ir", ir, NOP);
        chk("async_rst_pc1", pc1, 32'h0);
        chk("async_rst_flush", {31'h0, flush}, 32'h1);
        chk("async_rst_addr", imem_addr, 32'h0);
        chk("async_rst_perf_fetch", perf_fetch_cnt, 32'h0);
        chk("async_rst_perf_bubble", perf_bubble_cnt, 32'h0);
        next_cycle();
        rst = 1'b0;

        // Boot repeats; a stall during boot is ignored.
        @(negedge clk);
        chk("reboot0_flush", {31'h0, flush}, 32'h1);
        chk("reboot0_ir", ir, NOP);
        chk("reboot0_addr", imem_addr, 32'h0);
        next_cycle();
        stall = 1'b0;
        @(negedge clk);
        chk("reboot1_flush", {31'h0, flush}, 32'h0);
        chk("reboot1_ir", ir, 32'h0050_0093);
        chk("reboot1_pc1", pc1, 32'h0);
        chk("reboot1_addr", imem_addr, 32'h4);
        next_cycle();
        @(negedge clk);
        chk("reboot2_pc1", pc1, 32'h4);
        chk("reboot2_ir", ir, 32'h0010_0113);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
